prbs_link_test_ctrl: RTL and testbench

//  Sequences one PRBS link test through the 16-bit PRBS generator: comma alignment, PRBS run, optional error injection, flush.

---
 rtl/prbs_pkg.sv | 36 +++
 rtl/prbs_link_test_ctrl_if.sv | 38 +++
 rtl/prbs_err_scheduler.sv | 45 ++++
 rtl/prbs_link_test_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_prbs_link_test_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS link-test slice.
//  - ctrl_state_e : link-test controller state encoding (also read back on STATE)
//  - KCHAR_WORD   : comma word the generator emits while START is low
//  - ERR_WORD     : word the generator emits for an ERROR_IN pulse
//  - char_out_e   : generator CHAR_OUT codes
//  - STATUS_*     : bit positions inside the sticky STATUS vector
//  - sat_inc16    : saturating 16-bit increment
package prbs_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StAlign = 3'd1,
    StRun   = 3'd2,
    StFlush = 3'd3,
    StDone  = 3'd4
  } ctrl_state_e;

  localparam logic [15:0] KCHAR_WORD = 16'hBC3C;
  localparam logic [15:0] ERR_WORD   = 16'hEFFE;

  typedef enum logic [1:0] {
    CharData = 2'd0,
    CharK285 = 2'd1,
    CharK281 = 2'd2,
    CharErr  = 2'd3
  } char_out_e;

  localparam int unsigned STATUS_ABORTED   = 0;
  localparam int unsigned STATUS_TIMEOUT   = 1;
  localparam int unsigned STATUS_LINK_LOST = 2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/prbs_link_test_ctrl_if.sv
// Bundle between slow control / transceiver side and the link-test controller.
//  master : slow-control side; drives commands, test configuration and link_ready
//  slave  : controller side; drives generator controls, status and debug state
//  cmd_start/cmd_abort : 1-cycle command pulses
//  test_len, err_period, err_en : test configuration, sampled on accepted start
//  link_ready          : lane aligned/locked indication
//  prbs_start, prbs_error : to generator START / ERROR_IN
//  busy, done, word_cnt, err_inj_cnt, status, state : completion and status readback
interface prbs_link_test_ctrl_if;
  import prbs_pkg::*;

  logic        cmd_start;
  logic        cmd_abort;
  logic [31:0] test_len;
  logic [15:0] err_period;
  logic        err_en;
  logic        link_ready;

  logic        prbs_start;
  logic        prbs_error;
  logic        busy;
  logic        done;
  logic [31:0] word_cnt;
  logic [15:0] err_inj_cnt;
  logic [2:0]  status;
  ctrl_state_e state;

  modport master (
    output cmd_start, cmd_abort, test_len, err_period, err_en, link_ready,
    input  prbs_start, prbs_error, busy, done, word_cnt, err_inj_cnt, status, state
  );

  modport slave (
    input  cmd_start, cmd_abort, test_len, err_period, err_en, link_ready,
    output prbs_start, prbs_error, busy, done, word_cnt, err_inj_cnt, status, state
  );

endinterface

// File: rtl/prbs_err_scheduler.sv
// Reloadable down-counter that schedules error-injection pulses.
//  CLK, RESETGN : clock, synchronous active-low reset
//  load         : counter is (re)started this edge; next cycle is the first counted one
//  enable       : counting continues into the next cycle
//  period       : words between pulses (reload value is period-1)
//  tick         : registered; high in the cycle where the count reaches 0
// tick is computed one edge ahead from the next count value so it is a clean flop
// output aligned with the cycle it belongs to. With neither load nor enable it drops.
module prbs_err_scheduler (
  input  logic        CLK,
  input  logic        RESETGN,
  input  logic        load,
  input  logic        enable,
  input  logic [15:0] period,
  output logic        tick
);

  logic [15:0] cnt_q, cnt_d;
  logic        tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (load) begin
      cnt_d  = period - 16'd1;
      tick_d = (cnt_d == 16'd0);
    end else if (enable) begin
      cnt_d  = (cnt_q == 16'd0) ? period - 16'd1 : cnt_q - 16'd1;
      tick_d = (cnt_d == 16'd0);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETGN) begin
      cnt_q  <= 16'd0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/prbs_link_test_ctrl.sv
// Sequences one PRBS link test through the 16-bit PRBS generator of one serial lane:
// comma alignment, PRBS run with optional periodic error injection, flush, completion.
//  CLK     : clock
//  RESETGN : synchronous active-low reset
//  bus     : slave side of prbs_link_test_ctrl_if (commands/config in, generator
//            controls, counters, sticky status and debug state out)
// Parameters:
//  ALIGN_CYCLES  : consecutive link_ready cycles needed in ALIGN before RUN
//  ALIGN_TIMEOUT : ALIGN cycles after which the test gives up with TIMEOUT
//  FLUSH_CYCLES  : cycles START stays low after RUN (>= 2, generator latch latency)
// Every output is a flop; PRBS_START is high exactly in RUN cycles.
module prbs_link_test_ctrl
  import prbs_pkg::*;
#(
  parameter int unsigned ALIGN_CYCLES  = 64,
  parameter int unsigned ALIGN_TIMEOUT = 65535,
  parameter int unsigned FLUSH_CYCLES  = 4
) (
  input logic                  CLK,
  input logic                  RESETGN,
  prbs_link_test_ctrl_if.slave bus
);

  ctrl_state_e state_q, state_d;

  logic [31:0] align_cnt_q, align_cnt_d;
  logic [31:0] align_tmr_q, align_tmr_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [15:0] err_inj_cnt_q, err_inj_cnt_d;
  logic [2:0]  status_q, status_d;

  // Configuration shadowed at accepted start so slow control may change it mid-test.
  logic [31:0] test_len_q, test_len_d;
  logic [15:0] err_period_q, err_period_d;
  logic        err_en_q, err_en_d;

  logic        prbs_start_q;
  logic        busy_q;
  logic        done_q;

  logic        inj_ok;
  logic        sched_load;
  logic        sched_en;
  logic        sched_tick;

  assign inj_ok = err_en_q && (err_period_q != 16'd0);

  always_comb begin
    state_d       = state_q;
    align_cnt_d   = align_cnt_q;
    align_tmr_d   = align_tmr_q;
    flush_cnt_d   = flush_cnt_q;
    word_cnt_d    = word_cnt_q;
    err_inj_cnt_d = err_inj_cnt_q;
    status_d      = status_q;
    test_len_d    = test_len_q;
    err_period_d  = err_period_q;
    err_en_d      = err_en_q;

    // sched_tick is the PRBS_ERROR flop, so it only fires in RUN cycles.
    if (sched_tick) begin
      err_inj_cnt_d = sat_inc16(err_inj_cnt_q);
    end

    case (state_q)
      StIdle: begin
        // Abort in the same cycle wins: the start is simply not accepted.
        if (bus.cmd_start && !bus.cmd_abort) begin
          test_len_d    = bus.test_len;
          err_period_d  = bus.err_period;
          err_en_d      = bus.err_en;
          word_cnt_d    = 32'd0;
          err_inj_cnt_d = 16'd0;
          status_d      = 3'b000;
          align_cnt_d   = 32'd0;
          align_tmr_d   = 32'd0;
          state_d       = (bus.test_len == 32'd0) ? StDone : StAlign;
        end
      end

      StAlign: begin
        align_tmr_d = align_tmr_q + 32'd1;
        align_cnt_d = bus.link_ready ? align_cnt_q + 32'd1 : 32'd0;
        if (bus.cmd_abort) begin
          status_d[STATUS_ABORTED] = 1'b1;
          flush_cnt_d              = 32'd0;
          state_d                  = StFlush;
        end else if (bus.link_ready && (align_cnt_q == 32'(ALIGN_CYCLES - 1))) begin
          state_d = StRun;
        end else if (align_tmr_q == 32'(ALIGN_TIMEOUT - 1)) begin
          status_d[STATUS_TIMEOUT] = 1'b1;
          state_d                  = StDone;
        end
      end

      StRun: begin
        // This cycle already carried a PRBS word, whichever way RUN is left.
        word_cnt_d  = word_cnt_q + 32'd1;
        flush_cnt_d = 32'd0;
        if (bus.cmd_abort) begin
          status_d[STATUS_ABORTED] = 1'b1;
          state_d                  = StFlush;
        end else if (!bus.link_ready) begin
          status_d[STATUS_LINK_LOST] = 1'b1;
          state_d                    = StFlush;
        end else if (word_cnt_d == test_len_q) begin
          state_d = StFlush;
        end
      end

      StFlush: begin
        flush_cnt_d = flush_cnt_q + 32'd1;
        if (flush_cnt_q == 32'(FLUSH_CYCLES - 1)) begin
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Scheduler only runs while injection is armed; otherwise its tick stays low.
  assign sched_load = inj_ok && (state_q != StRun) && (state_d == StRun);
  assign sched_en   = inj_ok && (state_q == StRun) && (state_d == StRun);

  prbs_err_scheduler u_err_sched (
    .CLK     (CLK),
    .RESETGN (RESETGN),
    .load    (sched_load),
    .enable  (sched_en),
    .period  (err_period_q),
    .tick    (sched_tick)
  );

  always_ff @(posedge CLK) begin
    if (!RESETGN) begin
      state_q       <= StIdle;
      align_cnt_q   <= 32'd0;
      align_tmr_q   <= 32'd0;
      flush_cnt_q   <= 32'd0;
      word_cnt_q    <= 32'd0;
      err_inj_cnt_q <= 16'd0;
      status_q      <= 3'b000;
      test_len_q    <= 32'd0;
      err_period_q  <= 16'd0;
      err_en_q      <= 1'b0;
      prbs_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      align_cnt_q   <= align_cnt_d;
      align_tmr_q   <= align_tmr_d;
      flush_cnt_q   <= flush_cnt_d;
      word_cnt_q    <= word_cnt_d;
      err_inj_cnt_q <= err_inj_cnt_d;
      status_q      <= status_d;
      test_len_q    <= test_len_d;
      err_period_q  <= err_period_d;
      err_en_q      <= err_en_d;
      // Decoded from the next state so the flops line up with STATE.
      prbs_start_q  <= (state_d == StRun);
      busy_q        <= (state_d != StIdle);
      done_q        <= (state_d == StDone);
    end
  end

  assign bus.prbs_start  = prbs_start_q;
  assign bus.prbs_error  = sched_tick;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.word_cnt    = word_cnt_q;
  assign bus.err_inj_cnt = err_inj_cnt_q;
  assign bus.status      = status_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_prbs_link_test_ctrl.sv
module tb_prbs_link_test_ctrl;

  logic clk;
  logic resetgn;

  prbs_link_test_ctrl_if bus ();

  prbs_link_test_ctrl #(
    .ALIGN_CYCLES  (64),
    .ALIGN_TIMEOUT (200),
    .FLUSH_CYCLES  (4)
  ) dut (
    .CLK     (clk),
    .RESETGN (resetgn),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wc;
    logic [15:0] ec;
    logic [2:0]  st;
  } exp_t;

  exp_t exp_q[$];
  int   exp_err_q[$];
  int   err_seen[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Filled by observe(); read by the test tasks.
  int          obs_align, obs_run, obs_flush, obs_tail, obs_bad;
  bit          obs_done, obs_idle_after;
  logic [31:0] obs_wc;
  logic [15:0] obs_ec;
  logic [2:0]  obs_st;

  task automatic issue_start(input logic [31:0] len, input logic [15:0] per, input logic en);
    bus.test_len   = len;
    bus.err_period = per;
    bus.err_en     = en;
    bus.cmd_start  = 1'b1;
    @(negedge clk);
    bus.cmd_start  = 1'b0;
  endtask

  // Steps one cycle per negedge, optionally disturbing the test, until DONE or budget.
  task automatic observe(input int budget, input int abort_run, input int drop_run,
                         input int drop_at, input int drop_len, input int spur_run);
    int a_idx = 0;
    int r_idx = 0;
    obs_align = 0; obs_run = 0; obs_flush = 0; obs_tail = 0; obs_bad = 0;
    obs_done = 1'b0; obs_idle_after = 1'b0;
    err_seen.delete();
    for (int c = 0; c < budget; c++) begin
      if (bus.prbs_start !== (bus.state == 3'd2)) obs_bad++;
      if (bus.prbs_error === 1'b1 && bus.state != 3'd2) obs_bad++;
      if (bus.busy !== (bus.state != 3'd0)) obs_bad++;
      bus.cmd_abort = 1'b0;
      bus.cmd_start = 1'b0;
      if (bus.state == 3'd1) begin
        a_idx++;
        bus.link_ready = !(drop_len != 0 && a_idx >= drop_at && a_idx < drop_at + drop_len);
        if (bus.link_ready) obs_tail++;
        else obs_tail = 0;
      end
      if (bus.state == 3'd3) obs_flush++;
      if (bus.prbs_start === 1'b1) begin
        r_idx++;
        if (bus.prbs_error === 1'b1) err_seen.push_back(r_idx);
        if (r_idx == abort_run) bus.cmd_abort = 1'b1;
        if (r_idx == drop_run) bus.link_ready = 1'b0;
        if (r_idx == spur_run) begin
          bus.cmd_start = 1'b1;
          bus.test_len  = 32'd7;
        end
      end
      if (bus.done === 1'b1) begin
        obs_done = 1'b1;
        obs_wc   = bus.word_cnt;
        obs_ec   = bus.err_inj_cnt;
        obs_st   = bus.status;
        @(negedge clk);
        obs_idle_after = (bus.state == 3'd0) && (bus.busy === 1'b0) && (bus.done === 1'b0);
        break;
      end
      @(negedge clk);
    end
    obs_align      = a_idx;
    obs_run        = r_idx;
    bus.cmd_abort  = 1'b0;
    bus.cmd_start  = 1'b0;
    bus.link_ready = 1'b1;
  endtask

  task automatic test_reset();
    resetgn = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.state, bus.prbs_start, bus.prbs_error, bus.busy, bus.done, bus.status,
         bus.word_cnt, bus.err_inj_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: state=%0d start=%b busy=%b wc=%0d required all zero",
               bus.state, bus.prbs_start, bus.busy, bus.word_cnt);
    end
    resetgn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    exp_t e;
    exp_q.push_back('{wc: 32'd100, ec: 16'd0, st: 3'b000});
    issue_start(32'd100, 16'd0, 1'b0);
    observe(600, 0, 0, 0, 0, 0);
    e = exp_q.pop_front();
    n_checks++;
    if (!obs_done) begin n_fail++; $display("FAIL basic_done: done=0 required 1"); end
    n_checks++;
    if (obs_wc !== e.wc || obs_ec !== e.ec || obs_st !== e.st) begin
      n_fail++;
      $display("FAIL basic_result: wc=%0d ec=%0d st=%b required wc=%0d ec=%0d st=%b",
               obs_wc, obs_ec, obs_st, e.wc, e.ec, e.st);
    end
    n_checks++;
    if (obs_align != 64 || obs_run != 100 || obs_flush != 4) begin
      n_fail++;
      $display("FAIL basic_phases: align=%0d run=%0d flush=%0d required 64/100/4",
               obs_align, obs_run, obs_flush);
    end
    n_checks++;
    if (obs_bad != 0 || !obs_idle_after) begin
      n_fail++;
      $display("FAIL basic_outputs: violations=%0d idle_after=%0d required 0/1",
               obs_bad, obs_idle_after);
    end
  endtask

  task automatic test_err_inject();
    exp_t e;
    exp_q.push_back('{wc: 32'd1000, ec: 16'd10, st: 3'b000});
    for (int k = 1; k <= 10; k++) exp_err_q.push_back(k * 100);
    issue_start(32'd1000, 16'd100, 1'b1);
    observe(1300, 0, 0, 0, 0, 0);
    e = exp_q.pop_front();
    n_checks++;
    if (!obs_done || obs_wc !== e.wc || obs_ec !== e.ec || obs_st !== e.st) begin
      n_fail++;
      $display("FAIL inject_result: done=%0d wc=%0d ec=%0d st=%b required wc=%0d ec=%0d st=%b",
               obs_done, obs_wc, obs_ec, obs_st, e.wc, e.ec, e.st);
    end
    n_checks++;
    if (err_seen.size() != exp_err_q.size()) begin
      n_fail++;
      $display("FAIL inject_pulses: got %0d pulses required %0d",
               err_seen.size(), exp_err_q.size());
    end
    while (exp_err_q.size() > 0 && err_seen.size() > 0) begin
      int want;
      int got;
      want = exp_err_q.pop_front();
      got  = err_seen.pop_front();
      n_checks++;
      if (got != want) begin
        n_fail++;
        $display("FAIL inject_pos: pulse at run cycle %0d required %0d", got, want);
      end
    end
    exp_err_q.delete();
    n_checks++;
    if (obs_bad != 0) begin
      n_fail++;
      $display("FAIL inject_outputs: violations=%0d required 0", obs_bad);
    end
  endtask

  task automatic test_align_retry();
    exp_q.push_back('{wc: 32'd20, ec: 16'd0, st: 3'b000});
    issue_start(32'd20, 16'd0, 1'b0);
    observe(400, 0, 0, 30, 5, 0);
    n_checks++;
    if (obs_tail != 64 || obs_align != 29 + 5 + 64) begin
      n_fail++;
      $display("FAIL align_retry: tail=%0d align=%0d required 64/%0d",
               obs_tail, obs_align, 29 + 5 + 64);
    end
    begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (!obs_done || obs_wc !== e.wc || obs_st !== e.st) begin
        n_fail++;
        $display("FAIL align_result: wc=%0d st=%b required wc=%0d st=%b",
                 obs_wc, obs_st, e.wc, e.st);
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    exp_q.push_back('{wc: 32'd0, ec: 16'd0, st: 3'b010});
    issue_start(32'd50, 16'd0, 1'b0);
    observe(400, 0, 0, 1, 100000, 0);
    e = exp_q.pop_front();
    n_checks++;
    if (!obs_done || obs_wc !== e.wc || obs_ec !== e.ec || obs_st !== e.st) begin
      n_fail++;
      $display("FAIL timeout_result: done=%0d wc=%0d st=%b required wc=%0d st=%b",
               obs_done, obs_wc, obs_st, e.wc, e.st);
    end
    n_checks++;
    if (obs_align != 200 || obs_run != 0) begin
      n_fail++;
      $display("FAIL timeout_phases: align=%0d run=%0d required 200/0", obs_align, obs_run);
    end
  endtask

  task automatic test_abort();
    exp_t e;
    exp_q.push_back('{wc: 32'd50, ec: 16'd0, st: 3'b001});
    issue_start(32'd100, 16'd0, 1'b0);
    observe(600, 50, 0, 0, 0, 10);
    e = exp_q.pop_front();
    n_checks++;
    if (!obs_done || obs_wc !== e.wc || obs_ec !== e.ec || obs_st !== e.st) begin
      n_fail++;
      $display("FAIL abort_result: done=%0d wc=%0d st=%b required wc=%0d st=%b",
               obs_done, obs_wc, obs_st, e.wc, e.st);
    end
    n_checks++;
    if (obs_flush != 4 || obs_run != 50) begin
      n_fail++;
      $display("FAIL abort_phases: flush=%0d run=%0d required 4/50", obs_flush, obs_run);
    end
  endtask

  task automatic test_start_abort_same();
    bus.test_len  = 32'd9;
    bus.cmd_start = 1'b1;
    bus.cmd_abort = 1'b1;
    @(negedge clk);
    bus.cmd_start = 1'b0;
    bus.cmd_abort = 1'b0;
    n_checks++;
    if (bus.state != 3'd0 || bus.busy !== 1'b0 || bus.status !== 3'b001 ||
        bus.word_cnt !== 32'd50) begin
      n_fail++;
      $display("FAIL start_abort_same: state=%0d busy=%b st=%b wc=%0d required 0/0/001/50",
               bus.state, bus.busy, bus.status, bus.word_cnt);
    end
  endtask

  task automatic test_link_lost();
    exp_t e;
    exp_q.push_back('{wc: 32'd30, ec: 16'd0, st: 3'b100});
    issue_start(32'd100, 16'd0, 1'b0);
    observe(600, 0, 30, 0, 0, 0);
    e = exp_q.pop_front();
    n_checks++;
    if (!obs_done || obs_wc !== e.wc || obs_st !== e.st) begin
      n_fail++;
      $display("FAIL link_lost: done=%0d wc=%0d st=%b required wc=%0d st=%b",
               obs_done, obs_wc, obs_st, e.wc, e.st);
    end
  endtask

  task automatic test_err_period_edges();
    exp_t e;
    exp_q.push_back('{wc: 32'd5, ec: 16'd5, st: 3'b000});
    exp_q.push_back('{wc: 32'd5, ec: 16'd0, st: 3'b000});
    issue_start(32'd5, 16'd1, 1'b1);
    observe(300, 0, 0, 0, 0, 0);
    e = exp_q.pop_front();
    n_checks++;
    if (!obs_done || obs_ec !== e.ec || obs_wc !== e.wc || err_seen.size() != 5) begin
      n_fail++;
      $display("FAIL period_one: ec=%0d pulses=%0d required ec=%0d pulses=5",
               obs_ec, err_seen.size(), e.ec);
    end
    issue_start(32'd5, 16'd0, 1'b1);
    observe(300, 0, 0, 0, 0, 0);
    e = exp_q.pop_front();
    n_checks++;
    if (!obs_done || obs_ec !== e.ec || obs_wc !== e.wc || err_seen.size() != 0) begin
      n_fail++;
      $display("FAIL period_zero: ec=%0d pulses=%0d required ec=%0d pulses=0",
               obs_ec, err_seen.size(), e.ec);
    end
  endtask

  task automatic test_reset_mid_run();
    int r = 0;
    exp_t e;
    issue_start(32'd100, 16'd10, 1'b1);
    for (int c = 0; c < 300; c++) begin
      if (bus.prbs_start === 1'b1) r++;
      if (r == 20) break;
      @(negedge clk);
    end
    n_checks++;
    if (r != 20) begin n_fail++; $display("FAIL reset_reach_run: run=%0d required 20", r); end
    resetgn = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.prbs_start !== 1'b0 || bus.state != 3'd0 || bus.word_cnt !== 32'd0 ||
        bus.err_inj_cnt !== 16'd0 || bus.status !== 3'b000 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_run: start=%b state=%0d wc=%0d ec=%0d required 0/0/0/0",
               bus.prbs_start, bus.state, bus.word_cnt, bus.err_inj_cnt);
    end
    resetgn = 1'b1;
    @(negedge clk);
    exp_q.push_back('{wc: 32'd0, ec: 16'd0, st: 3'b000});
    issue_start(32'd0, 16'd0, 1'b0);
    e = exp_q.pop_front();
    n_checks++;
    if (bus.state != 3'd4 || bus.done !== 1'b1 || bus.prbs_start !== 1'b0 ||
        bus.word_cnt !== e.wc || bus.status !== e.st) begin
      n_fail++;
      $display("FAIL len_zero: state=%0d done=%b start=%b wc=%0d required 4/1/0/%0d",
               bus.state, bus.done, bus.prbs_start, bus.word_cnt, e.wc);
    end
    @(negedge clk);
    n_checks++;
    if (bus.state != 3'd0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL len_zero_idle: state=%0d done=%b required 0/0", bus.state, bus.done);
    end
  endtask

  initial begin
    resetgn        = 1'b0;
    bus.cmd_start  = 1'b0;
    bus.cmd_abort  = 1'b0;
    bus.test_len   = 32'd0;
    bus.err_period = 16'd0;
    bus.err_en     = 1'b0;
    bus.link_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_err_inject();
    test_align_retry();
    test_timeout();
    test_abort();
    test_start_abort_same();
    test_link_lost();
    test_err_period_edges();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
